fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Consumes the hazard controls (if_id_regOption, PCSrc2, redirects) and drives the front end: PC register,
//  single-outstanding instruction-memory request/response handshake, one-entry skid buffer and the IF/ID register.
//  Sits between instruction memory and decode.
//  Discards stale memory responses after branch/jump redirects and preserves a fetched word across IF/ID holds.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset; first fetch address
//  ADDR_W    32             PC / address width
//  INST_W    32             instruction width
// PORTS
//  clk                  in   1       single clock, rising edge
//  reset                in   1       asynchronous, active-high
//  if_id_regOption      in   2       00 normal, 01 flush, 10 hold (IF/ID register)
//  PCSrc2               in   1       1 = hold PC, issue no new request
//  ex_mem_activeBranch  in   1       taken branch, highest priority redirect
//  branch_target        in   ADDR_W  target when ex_mem_activeBranch
//  id_ex_PCSrc1         in   2       00 seq, 01 jump (jump_target), 10 jr (jr_target), 11 seq
//  jump_target          in   ADDR_W
//  jr_target            in   ADDR_W
//  imem_req             out  1       request valid
//  imem_addr            out  ADDR_W  request address (= pc)
//  imem_gnt             in   1       request accepted this cycle (req&&gnt = handshake)
//  imem_rvalid          in   1       response valid (>=1 cycle after gnt)
//  imem_rdata           in   INST_W  response data
//  if_id_inst           out  INST_W  IF/ID instruction
//  if_id_PC             out  ADDR_W  IF/ID PC+4 of that instruction
//  if_id_valid          out  1       IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=IDLE, skid empty, if_id_inst=0, if_id_PC=0, if_id_valid=0; imem_req=0 during reset.
//  Redirect priority: activeBranch > PCSrc1==01/10 > PCSrc2 hold > sequential. Redirect cycle: pc<=target, imem_req=0.
//  FSM: IDLE (none outstanding) / WAIT (outstanding, live) / WAIT_KILL (outstanding, stale).
//   IDLE: imem_req=1 unless redirect, PCSrc2, or skid full; on gnt: pc<=pc+4, ->WAIT.
//   WAIT: rvalid -> deliver; imem_req may assert same cycle (back-to-back); gnt -> stay WAIT, else ->IDLE.
//   WAIT: redirect without rvalid -> WAIT_KILL; redirect with rvalid -> data dropped, ->IDLE.
//   WAIT_KILL: imem_req=0; rvalid -> discard, ->IDLE; further redirect only updates pc.
//  Delivered word tagged with its fetch address+4; pc+4 wraps modulo 2^ADDR_W.
//  IF/ID update on regOption: 00 loads skid if full (skid drains), else live response, else bubble (inst=0, valid=0);
//   01 clears to bubble and empties skid; 10 holds all IF/ID fields, live response goes into skid.
//  Skid full blocks new requests; at most one outstanding request, so skid never overflows.
//  rvalid in IDLE (no outstanding) is a protocol error: ignored; assertion in sim.
//  reset asserted mid-transaction: outstanding request forgotten; late rvalid after reset hits IDLE rule.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cyc[31:0] (cycles with regOption==10 or PCSrc2) and
//   perf_kill_cnt[15:0] (responses discarded in WAIT_KILL or on redirect); both saturate, reset to 0.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  pipe_pkg: REG_NORMAL=2'b00, REG_FLUSH=2'b01, REG_HOLD=2'b10; PCSRC_SEQ/JUMP/JR encodings;
//   NOP_INST=32'h0; fetch FSM state enum (IDLE, WAIT, WAIT_KILL).
//  Sub-module fetch_skid_buf: one-entry {inst, pc4} buffer with push/pop/clear, full flag.
// TESTING
//  reset, gnt tied 1, rvalid 1 cycle after gnt, data=addr -> imem_addr 0,4,8,...; if_id_PC 4,8,...; valid=1.
//  hold regOption=10 for 3 cycles with response arriving -> IF/ID frozen, word in skid, delivered on release.
//  redirect branch_target=0x100 while WAIT -> response dropped, if_id_valid=0, next imem_addr=0x100.
//  branch and PCSrc1=01 same cycle (targets 0x200/0x300) -> branch wins, next fetch 0x200.
//  gnt held 0 for 5 cycles -> imem_req/imem_addr stable, pc unchanged, IF/ID bubbles when regOption=00.
//  reset pulsed while WAIT, late rvalid -> ignored; first fetch from RESET_PC; perf_kill_cnt unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: IF/ID control and PC-source encodings, NOP word and fetch FSM state type.
package pipe_pkg;
    localparam logic [1:0]  REG_NORMAL = 2'b00;
    localparam logic [1:0]  REG_FLUSH  = 2'b01;
    localparam logic [1:0]  REG_HOLD   = 2'b10;
    localparam logic [1:0]  PCSRC_SEQ  = 2'b00;
    localparam logic [1:0]  PCSRC_JUMP = 2'b01;
    localparam logic [1:0]  PCSRC_JR   = 2'b10;
    localparam logic [31:0] NOP_INST   = 32'h0;
    typedef enum logic [1:0] {FS_IDLE, FS_WAIT, FS_WAIT_KILL} fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {inst, pc4} buffer catching a response that lands during an IF/ID hold.
module fetch_skid_buf #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_pc4,
    output logic              full,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc4
);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            full <= 1'b0;
            inst <= '0;
            pc4  <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            inst <= in_inst;
            pc4  <= in_pc4;
        end else if (pop) begin
            full <= 1'b0;
        end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding imem handshake, skid buffer and IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating stall-cycle and killed-response counters.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        if_id_regOption,
    input  logic              PCSrc2,
    input  logic              ex_mem_activeBranch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [1:0]        id_ex_PCSrc1,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] if_id_inst,
    output logic [ADDR_W-1:0] if_id_PC,
    output logic              if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [15:0]       perf_kill_cnt
`endif
);
    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, target, skid_pc4;
    logic [INST_W-1:0] skid_inst;
    logic              redirect, live, fire, hold, skid_full;

    assign hold      = if_id_regOption == REG_HOLD;
    assign redirect  = ex_mem_activeBranch || id_ex_PCSrc1 == PCSRC_JUMP || id_ex_PCSrc1 == PCSRC_JR;
    assign target    = ex_mem_activeBranch ? branch_target :
                       id_ex_PCSrc1 == PCSRC_JUMP ? jump_target : jr_target;
    // While WAIT, pc already points past the outstanding fetch, so it doubles as that word's PC+4.
    assign live      = state == FS_WAIT && imem_rvalid && !redirect;
    assign fire      = imem_req && imem_gnt;
    assign imem_addr = pc;

    always_comb begin
        imem_req = !reset && !redirect && !PCSrc2 && !skid_full && !(live && hold) &&
                   (state == FS_IDLE || live);
        state_n  = state;
        if (state == FS_IDLE && fire) state_n = FS_WAIT;
        else if (state == FS_WAIT && imem_rvalid) state_n = fire ? FS_WAIT : FS_IDLE;
        else if (state == FS_WAIT && redirect) state_n = FS_WAIT_KILL;
        else if (state == FS_WAIT_KILL && imem_rvalid) state_n = FS_IDLE;
        pc_n = redirect ? target : fire ? pc + ADDR_W'(4) : pc;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= FS_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end

    fetch_skid_buf #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .push    (live && hold),
        .pop     (!hold),
        .clear   (if_id_regOption == REG_FLUSH),
        .in_inst (imem_rdata),
        .in_pc4  (pc),
        .full    (skid_full),
        .inst    (skid_inst),
        .pc4     (skid_pc4)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            if_id_inst  <= '0;
            if_id_PC    <= '0;
            if_id_valid <= 1'b0;
        end else if (if_id_regOption == REG_FLUSH) begin
            if_id_inst  <= INST_W'(NOP_INST);
            if_id_PC    <= '0;
            if_id_valid <= 1'b0;
        end else if (!hold) begin
            if_id_inst  <= skid_full ? skid_inst : live ? imem_rdata : INST_W'(NOP_INST);
            if_id_PC    <= skid_full ? skid_pc4 : live ? pc : '0;
            if_id_valid <= skid_full || live;
        end

`ifdef FETCH_PERF_CNT_EN
    logic kill;
    assign kill = imem_rvalid && (state == FS_WAIT_KILL || (state == FS_WAIT && redirect));

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            perf_stall_cyc <= '0;
            perf_kill_cnt  <= '0;
        end else begin
            if ((hold || PCSrc2) && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (kill && perf_kill_cnt != '1) perf_kill_cnt <= perf_kill_cnt + 16'd1;
        end
`endif

    // A response with nothing outstanding means the memory broke the handshake.
    assert property (@(posedge clk) disable iff (reset) !(state == FS_IDLE && imem_rvalid))
        else $error("fetch_stage: imem_rvalid with no outstanding request");
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a transaction-level model.
module tb_fetch_stage;
    import pipe_pkg::*;

    localparam logic [31:0] SALT = 32'h5A5A_0000;

    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  if_id_regOption = 2'b00, id_ex_PCSrc1 = 2'b00;
    logic        PCSrc2 = 1'b0, ex_mem_activeBranch = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0, jr_target = '0, imem_rdata = '0;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_inst, if_id_PC;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [15:0] perf_kill_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .if_id_regOption     (if_id_regOption),
        .PCSrc2              (PCSrc2),
        .ex_mem_activeBranch (ex_mem_activeBranch),
        .branch_target       (branch_target),
        .id_ex_PCSrc1        (id_ex_PCSrc1),
        .jump_target         (jump_target),
        .jr_target           (jr_target),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_gnt            (imem_gnt),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .if_id_inst          (if_id_inst),
        .if_id_PC            (if_id_PC),
        .if_id_valid         (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cyc      (perf_stall_cyc),
        .perf_kill_cnt       (perf_kill_cnt)
`endif
    );

    int errors = 0, checks = 0;

    // model: one fetch in flight (address + stale flag), a skid slot and the IF/ID contents
    logic [31:0] m_pc, m_out_addr, m_skid_inst, m_skid_pc4, m_inst, m_pc4;
    bit          m_out, m_stale, m_skid_v, m_valid;
    int unsigned m_stall, m_kill;

    // memory: at most one pending response, returned mem_left cycles after grant
    bit          mem_pend = 0;
    int          mem_left = 0, lat_cfg = 1;
    logic [31:0] mem_addr = '0;
    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ SALT;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_stale = 0; m_out_addr = '0;
        m_skid_v = 0; m_skid_inst = '0; m_skid_pc4 = '0;
        m_valid = 0; m_inst = '0; m_pc4 = '0; m_stall = 0; m_kill = 0;
    endtask

    task automatic check_regs();
        chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        chk("if_id_inst", if_id_inst, m_inst);
        if (m_valid) chk("if_id_PC", if_id_PC, m_pc4);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_stall_cyc", perf_stall_cyc, m_stall);
        chk("perf_kill_cnt", 32'(perf_kill_cnt), m_kill);
`endif
    endtask

    task automatic step(input logic [1:0] ro, input bit p2, input bit br, input logic [31:0] bt,
                        input logic [1:0] s1, input logic [31:0] jt, input logic [31:0] jrt,
                        input bit g);
        bit          redir, live, exp_req;
        logic [31:0] tgt;
        if_id_regOption = ro; PCSrc2 = p2; ex_mem_activeBranch = br; branch_target = bt;
        id_ex_PCSrc1 = s1; jump_target = jt; jr_target = jrt; imem_gnt = g;
        imem_rvalid = 1'b0; imem_rdata = $urandom;
        if (mem_pend) begin
            if (mem_left == 1) begin
                imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr); mem_pend = 0;
            end else mem_left--;
        end
        #1;
        redir = br || s1 == PCSRC_JUMP || s1 == PCSRC_JR;
        tgt   = br ? bt : s1 == PCSRC_JUMP ? jt : jrt;
        live  = m_out && !m_stale && imem_rvalid && !redir;
        // a new fetch needs a free slot downstream and either nothing in flight or the live one finishing
        exp_req = !redir && !p2 && !m_skid_v && !(live && ro == REG_HOLD) && (!m_out || live);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        last_req = imem_req; last_addr = imem_addr;
        if (imem_req && g) begin
            mem_pend = 1; mem_addr = imem_addr;
            mem_left = lat_cfg != 0 ? lat_cfg : int'($urandom_range(1, 3));
        end
        if (ro == REG_HOLD || p2) m_stall++;
        if (m_out && imem_rvalid && (m_stale || redir)) m_kill++;
        if (ro == REG_FLUSH) begin
            m_valid = 0; m_inst = '0; m_skid_v = 0;
        end else if (ro == REG_HOLD) begin
            if (live) begin m_skid_v = 1; m_skid_inst = mem_word(m_out_addr); m_skid_pc4 = m_out_addr + 4; end
        end else if (m_skid_v) begin
            m_valid = 1; m_inst = m_skid_inst; m_pc4 = m_skid_pc4; m_skid_v = 0;
        end else if (live) begin
            m_valid = 1; m_inst = mem_word(m_out_addr); m_pc4 = m_out_addr + 4;
        end else begin
            m_valid = 0; m_inst = '0;
        end
        if (m_out && imem_rvalid) m_out = 0;
        else if (m_out && redir) m_stale = 1;
        if (exp_req && g) begin m_out = 1; m_stale = 0; m_out_addr = m_pc; end
        m_pc = redir ? tgt : (exp_req && g) ? m_pc + 4 : m_pc;
        @(posedge clk); #1;
        check_regs();
    endtask

    task automatic nrm(input logic [1:0] ro, input bit g);
        step(ro, 0, 0, '0, PCSRC_SEQ, '0, '0, g);
    endtask

    function automatic logic [31:0] rand_tgt();
        int r = int'($urandom_range(0, 3));
        return r == 0 ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset imem_req", 32'(imem_req), 0);
        chk("reset if_id_valid", 32'(if_id_valid), 0);
        chk("reset if_id_inst", if_id_inst, 0);
        chk("reset if_id_PC", if_id_PC, 0);
        reset = 1'b0;

        lat_cfg = 1;
        nrm(REG_NORMAL, 1); chk("seq addr0", last_addr, 32'h0);
        nrm(REG_NORMAL, 1); chk("seq addr1", last_addr, 32'h4);
        chk("seq first inst", if_id_inst, SALT);
        chk("seq first PC", if_id_PC, 32'h4);
        nrm(REG_NORMAL, 1); chk("seq addr2", last_addr, 32'h8);
        chk("seq second PC", if_id_PC, 32'h8);

        nrm(REG_HOLD, 1); chk("hold blocks req", 32'(last_req), 0);
        nrm(REG_HOLD, 1);
        nrm(REG_HOLD, 1); chk("hold frozen PC", if_id_PC, 32'h8);
        nrm(REG_NORMAL, 1);
        chk("skid drained PC", if_id_PC, 32'hC);
        chk("skid drained inst", if_id_inst, 32'h8 ^ SALT);

        lat_cfg = 2;
        nrm(REG_NORMAL, 1); chk("refetch addr", last_addr, 32'hC);
        step(REG_NORMAL, 0, 1, 32'h100, PCSRC_SEQ, '0, '0, 1);
        chk("redirect req low", 32'(last_req), 0);
        nrm(REG_NORMAL, 1);
        chk("stale dropped valid", 32'(if_id_valid), 0);
        lat_cfg = 1;
        nrm(REG_NORMAL, 1); chk("branch target fetch", last_addr, 32'h100);

        step(REG_NORMAL, 0, 1, 32'h200, PCSRC_JUMP, 32'h300, '0, 1);
        chk("priority drop valid", 32'(if_id_valid), 0);
        nrm(REG_NORMAL, 1); chk("branch beats jump", last_addr, 32'h200);

        nrm(REG_NORMAL, 0); chk("gnt0 addr", last_addr, 32'h204);
        chk("gnt0 delivered PC", if_id_PC, 32'h204);
        for (int i = 0; i < 4; i++) begin
            nrm(REG_NORMAL, 0);
            chk("gnt0 stable req", 32'(last_req), 1);
            chk("gnt0 stable addr", last_addr, 32'h204);
            chk("gnt0 bubble", 32'(if_id_valid), 0);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("kills before reset", 32'(perf_kill_cnt), 2);
`endif

        lat_cfg = 3;
        nrm(REG_NORMAL, 1);
        nrm(REG_NORMAL, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr);
        chk("mid reset req", 32'(imem_req), 0);
        @(posedge clk); #1;
        imem_rvalid = 1'b0; mem_pend = 0;
        model_reset();
        check_regs();
        reset = 1'b0;
        lat_cfg = 1;
        nrm(REG_NORMAL, 1); chk("post reset fetch", last_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("late rvalid not killed", 32'(perf_kill_cnt), 0);
`endif

        lat_cfg = 0;
        for (int i = 0; i < 3000; i++) begin
            int          r  = int'($urandom_range(0, 99));
            logic [1:0]  ro = r < 72 ? REG_NORMAL : r < 90 ? REG_HOLD : REG_FLUSH;
            int          s  = int'($urandom_range(0, 29));
            logic [1:0]  s1 = s == 0 ? PCSRC_JUMP : s == 1 ? PCSRC_JR : s == 2 ? 2'b11 : PCSRC_SEQ;
            step(ro, $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, rand_tgt(),
                 s1, rand_tgt(), rand_tgt(), $urandom_range(0, 9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
